// File: rtl/boost_ctrl_pkg.sv
// Shared types and defaults for the boost soft-start controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package boost_ctrl_pkg;

  localparam int DUTY_W       = 10;
  localparam int STEP_DEF     = 4;
  localparam int RAMP_DIV_DEF = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

endpackage

// File: rtl/boost_tick_div.sv
// Ramp-step divider: emits one step on every RAMP_DIV-th tick, cleared while outside RAMP.
// Latency: step is combinational from tick in the cycle the count reaches RAMP_DIV-1.
// Backpressure: none; ticks are counted only when presented.
module boost_tick_div
  import boost_ctrl_pkg::*;
#(
  parameter int RAMP_DIV = RAMP_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic clr,
  output logic step
);

  localparam logic [7:0] LAST = 8'(RAMP_DIV - 1);

  logic [7:0] r_cnt;
  logic       w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign step   = tick && !clr && w_wrap;

  // Tick counter: cleared on request, wraps to zero on the step tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (clr) begin
      r_cnt <= 8'd0;
    end else if (tick) begin
      r_cnt <= w_wrap ? 8'd0 : r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/boost_softstart_ctrl.sv
// Boost converter soft-start: ramps duty to target in STEP increments, tracks target, latches faults.
// Latency: state/duty update one clk after the causing input; duty only moves on PWM ticks except forced zeroing.
// Backpressure: none; ce=0 freezes tick/ramp activity. Optional clamp: define BOOST_DMAX_CLAMP_EN.
module boost_softstart_ctrl
  import boost_ctrl_pkg::*;
#(
  parameter int STEP     = STEP_DEF,
  parameter int RAMP_DIV = RAMP_DIV_DEF,
  parameter int D_MAX    = 900
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              clk_int,
  input  logic              en,
  input  logic              fault,
  input  logic [DUTY_W-1:0] d_target,
  output logic [DUTY_W-1:0] d_boost,
  output logic [1:0]        state,
  output logic              done
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DUTY_W-1:0]   r_duty;
  logic [DUTY_W-1:0]   w_duty_nxt;
  logic [DUTY_W-1:0]   w_tgt;
  logic [DUTY_W:0]     w_sum;
  logic [DUTY_W-1:0]   w_stepped;
  logic                w_tick;
  logic                w_step;
  logic                w_in_ramp;

  assign w_tick    = ce & clk_int;
  assign w_in_ramp = (r_state == ST_RAMP);

`ifdef BOOST_DMAX_CLAMP_EN
  assign w_tgt = (d_target > DUTY_W'(D_MAX)) ? DUTY_W'(D_MAX) : d_target;
`else
  assign w_tgt = d_target;
`endif

  // Sum is one bit wider than the duty so a step near full scale cannot wrap low.
  assign w_sum     = {1'b0, r_duty} + (DUTY_W+1)'(STEP);
  assign w_stepped = (w_sum >= {1'b0, w_tgt}) ? w_tgt : w_sum[DUTY_W-1:0];

  boost_tick_div #(
    .RAMP_DIV (RAMP_DIV)
  ) u_tick_div (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick & w_in_ramp),
    .clr   (!w_in_ramp),
    .step  (w_step)
  );

  // State and duty registers; reset discards all ramp progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_duty  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_duty  <= w_duty_nxt;
    end
  end

  // Next state and duty: fault beats disable, disable beats tick/step.
  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    if (fault) begin
      w_state_nxt = ST_FAULT;
      w_duty_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_duty_nxt = '0;
          if (en) w_state_nxt = ST_RAMP;
        end
        ST_RAMP: begin
          if (!en) begin
            w_state_nxt = ST_IDLE;
            w_duty_nxt  = '0;
          end else if (w_tick && (w_tgt < r_duty)) begin
            w_duty_nxt  = w_tgt;
            w_state_nxt = ST_RUN;
          end else if (w_step) begin
            w_duty_nxt = w_stepped;
            if (w_stepped == w_tgt) w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!en) begin
            w_state_nxt = ST_IDLE;
            w_duty_nxt  = '0;
          end else if (w_tick) begin
            if (w_tgt < r_duty) begin
              w_duty_nxt = w_tgt;
            end else if (w_tgt > r_duty) begin
              w_state_nxt = ST_RAMP;
            end
          end
        end
        ST_FAULT: begin
          w_duty_nxt = '0;
          if (!en) w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_duty_nxt  = '0;
        end
      endcase
    end
  end

  assign d_boost = r_duty;
  assign state   = r_state;
  assign done    = (r_state == ST_RUN);

endmodule

// File: tb/tb_boost_softstart_ctrl.sv
// Directed bench for boost_softstart_ctrl with a queue scoreboard.
// Driver pushes hand-computed expectations after each edge; monitor compares on the falling edge.
// Honours BOOST_DMAX_CLAMP_EN for the clamp expectations.
module tb_boost_softstart_ctrl;

  logic       clk;
  logic       rst_n;
  logic       ce;
  logic       clk_int;
  logic       en;
  logic       fault;
  logic [9:0] d_target;
  logic [9:0] d_boost;
  logic [1:0] state;
  logic       done;

  int n_checks;
  int n_fail;

  logic [9:0] q_d[$];
  logic [1:0] q_s[$];
  string      q_n[$];

  localparam logic [1:0] S_IDLE = 2'd0, S_RAMP = 2'd1, S_RUN = 2'd2, S_FAULT = 2'd3;

  boost_softstart_ctrl #(
    .STEP     (4),
    .RAMP_DIV (1),
    .D_MAX    (900)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .clk_int  (clk_int),
    .en       (en),
    .fault    (fault),
    .d_target (d_target),
    .d_boost  (d_boost),
    .state    (state),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expectation is consumed per falling edge.
  always @(negedge clk) begin
    if (q_d.size() > 0) begin
      logic [9:0] ed;
      logic [1:0] es;
      string      nm;
      ed = q_d.pop_front();
      es = q_s.pop_front();
      nm = q_n.pop_front();
      n_checks = n_checks + 3;
      if (d_boost !== ed) begin
        n_fail = n_fail + 1;
        $display("FAIL %s d_boost: got %0d expected %0d (t=%0t)", nm, d_boost, ed, $time);
      end
      if (state !== es) begin
        n_fail = n_fail + 1;
        $display("FAIL %s state: got %0d expected %0d (t=%0t)", nm, state, es, $time);
      end
      if (done !== (es == S_RUN)) begin
        n_fail = n_fail + 1;
        $display("FAIL %s done: got %0b expected %0b (t=%0t)", nm, done, (es == S_RUN), $time);
      end
    end
  end

  task automatic expect_now(input logic [9:0] ed, input logic [1:0] es, input string nm);
    q_d.push_back(ed);
    q_s.push_back(es);
    q_n.push_back(nm);
  endtask

  // One clk cycle with the given clk_int level, then queue the expected outcome.
  task automatic cyc(input logic ci, input logic [9:0] ed, input logic [1:0] es, input string nm);
    clk_int = ci;
    @(posedge clk);
    #1;
    clk_int = 1'b0;
    expect_now(ed, es, nm);
  endtask

  initial begin
    int clamp_ticks;
    logic [9:0] clamp_val;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    ce       = 1'b1;
    clk_int  = 1'b0;
    en       = 1'b0;
    fault    = 1'b0;
    d_target = 10'd100;

    // Reset state while rst_n is held low.
    @(posedge clk);
    #1;
    expect_now(10'd0, S_IDLE, "reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 10'd0, S_IDLE, "idle_no_en");

    // Basic ramp to 100: 25 ticks of 4.
    en = 1'b1;
    cyc(1'b0, 10'd0, S_RAMP, "enter_ramp");
    for (int k = 1; k <= 25; k++)
      cyc(1'b1, 10'(4 * k), (k == 25) ? S_RUN : S_RAMP, "ramp100");
    cyc(1'b1, 10'd100, S_RUN, "run_hold");
    d_target = 10'd102;
    cyc(1'b1, 10'd100, S_RAMP, "run_up_reramp");
    cyc(1'b1, 10'd102, S_RUN, "run_up_102");

    // Non-multiple target from scratch: 100 then 102, never 104.
    en = 1'b0;
    cyc(1'b1, 10'd0, S_IDLE, "disable_run");
    en = 1'b1;
    cyc(1'b0, 10'd0, S_RAMP, "enter_ramp2");
    for (int k = 1; k <= 25; k++)
      cyc(1'b1, 10'(4 * k), S_RAMP, "ramp102");
    cyc(1'b1, 10'd102, S_RUN, "ramp102_last");

    // Fault latch at 40, disable priority over tick.
    d_target = 10'd100;
    en = 1'b0;
    cyc(1'b1, 10'd0, S_IDLE, "disable2");
    en = 1'b1;
    cyc(1'b0, 10'd0, S_RAMP, "enter_ramp3");
    for (int k = 1; k <= 10; k++)
      cyc(1'b1, 10'(4 * k), S_RAMP, "ramp_to40");
    fault = 1'b1;
    cyc(1'b1, 10'd0, S_FAULT, "fault_hit");
    fault = 1'b0;
    cyc(1'b1, 10'd0, S_FAULT, "fault_latched");
    cyc(1'b0, 10'd0, S_FAULT, "fault_latched2");
    en = 1'b0;
    cyc(1'b0, 10'd0, S_IDLE, "fault_exit");
    en = 1'b1;
    fault = 1'b1;
    cyc(1'b0, 10'd0, S_FAULT, "fault_over_en");
    fault = 1'b0;
    en = 1'b0;
    cyc(1'b0, 10'd0, S_IDLE, "fault_exit2");
    en = 1'b1;
    cyc(1'b0, 10'd0, S_RAMP, "enter_ramp4");
    cyc(1'b1, 10'd4, S_RAMP, "ramp_4");
    en = 1'b0;
    cyc(1'b1, 10'd0, S_IDLE, "disable_over_tick");

    // Stall with ce low, then retarget down and up.
    d_target = 10'd200;
    en = 1'b1;
    cyc(1'b0, 10'd0, S_RAMP, "enter_ramp5");
    for (int k = 1; k <= 5; k++)
      cyc(1'b1, 10'(4 * k), S_RAMP, "ramp_pre_stall");
    ce = 1'b0;
    for (int k = 0; k < 50; k++)
      cyc(1'b1, 10'd20, S_RAMP, "stall");
    ce = 1'b1;
    for (int k = 6; k <= 50; k++)
      cyc(1'b1, 10'(4 * k), (k == 50) ? S_RUN : S_RAMP, "ramp200");
    d_target = 10'd60;
    cyc(1'b0, 10'd200, S_RUN, "no_tick_hold");
    cyc(1'b1, 10'd60, S_RUN, "drop_to60");
    d_target = 10'd80;
    cyc(1'b0, 10'd60, S_RUN, "no_tick_hold2");
    cyc(1'b1, 10'd60, S_RAMP, "reramp_from60");
    for (int k = 16; k <= 20; k++)
      cyc(1'b1, 10'(4 * k), (k == 20) ? S_RUN : S_RAMP, "ramp60_80");

    // Full-scale target: clamp to 900 or reach 1023 without wrapping.
`ifdef BOOST_DMAX_CLAMP_EN
    clamp_ticks = 225;
    clamp_val   = 10'd900;
`else
    clamp_ticks = 256;
    clamp_val   = 10'd1023;
`endif
    en = 1'b0;
    cyc(1'b0, 10'd0, S_IDLE, "disable3");
    d_target = 10'd1023;
    en = 1'b1;
    cyc(1'b0, 10'd0, S_RAMP, "enter_ramp6");
    for (int k = 1; k < clamp_ticks; k++)
      cyc(1'b1, 10'(4 * k), S_RAMP, "ramp_full");
    cyc(1'b1, clamp_val, S_RUN, "full_settle");
    cyc(1'b1, clamp_val, S_RUN, "full_hold");

    // Asynchronous reset mid-run, then restart from zero.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    expect_now(10'd0, S_IDLE, "async_reset");
    @(posedge clk);
    #1;
    expect_now(10'd0, S_IDLE, "reset_held");
    rst_n = 1'b1;
    d_target = 10'd100;
    cyc(1'b0, 10'd0, S_RAMP, "restart_ramp");
    for (int k = 1; k <= 3; k++)
      cyc(1'b1, 10'(4 * k), S_RAMP, "restart_steps");

    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 10 && q_d.size() > 0; w++)
      @(negedge clk);
    #1;
    n_checks = n_checks + 1;
    if (q_d.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL drain: %0d expectations left, expected 0", q_d.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/boost_softstart_ctrl.md
BOOST_SOFTSTART_CTRL -- requirements
Module: boost_softstart_ctrl

Interface
REQ-001 The block SHALL have parameter STEP, default 4: duty increment per ramp step, in LSBs.
REQ-002 The block SHALL have parameter RAMP_DIV, default 1: number of PWM period ticks per ramp step, valid range 1..255.
REQ-003 The block SHALL have parameter D_MAX, default 900: duty ceiling, used only when the clamp feature is compiled in.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset.
REQ-005 Port clk, input, 1 bit: master clock.
REQ-006 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port ce, input, 1 bit: clock enable; it gates ramp and tick activity only.
REQ-008 Port clk_int, input, 1 bit: PWM period tick from the boost modulator, one clk wide.
REQ-009 Port en, input, 1 bit: converter enable request.
REQ-010 Port fault, input, 1 bit: overcurrent or overvoltage fault, active-high.
REQ-011 Port d_target, input, 10 bits: requested steady-state duty.
REQ-012 Port d_boost, output, 10 bits: duty word driving the boost modulator.
REQ-013 Port state, output, 2 bits: IDLE=0, RAMP=1, RUN=2, FAULT=3.
REQ-014 Port done, output, 1 bit: high exactly while state is RUN.

Function
REQ-015 A tick SHALL be defined as ce=1 and clk_int=1 in the same clk cycle.
REQ-016 A step SHALL be defined as every RAMP_DIV-th tick while in RAMP, counted by an 8-bit divider that clears on entry to RAMP.
REQ-017 The effective target tgt SHALL be d_target with the clamp applied per REQ-029/030, sampled on every tick.
REQ-018 IDLE: d_boost=0; when en=1 and fault=0, the block SHALL move to RAMP on the next clk edge, independent of ce.
REQ-019 RAMP: on each step, d_boost SHALL become min(d_boost+STEP, tgt), computed 11 bits wide so the sum never wraps.
REQ-020 RAMP: when the updated d_boost equals tgt, the block SHALL enter RUN on the same edge.
REQ-021 RAMP: if tgt < d_boost on a tick, d_boost SHALL take tgt and the block SHALL enter RUN.
REQ-022 RUN: tgt < d_boost on a tick SHALL load d_boost=tgt directly, with no step-down ramp.
REQ-023 RUN: tgt > d_boost on a tick SHALL return the block to RAMP with d_boost unchanged.
REQ-024 d_boost SHALL change only on tick edges, except on forced zeroing (REQ-025/026), so the modulator never sees a mid-period duty change.
REQ-025 When en=0 in RAMP or RUN, the block SHALL go to IDLE with d_boost=0 on the next clk edge, regardless of ce or tick.
REQ-026 When fault=1 in any state, the block SHALL go to FAULT with d_boost=0 on the next clk edge, regardless of ce.
REQ-027 FAULT SHALL be exited to IDLE only when fault=0 and en=0 are both present; en held high keeps the block latched in FAULT.
REQ-028 Priority SHALL be fault over en=0 over tick or step; all simultaneous events SHALL resolve in one edge.

Configuration
REQ-029 With BOOST_DMAX_CLAMP_EN defined, tgt SHALL equal min(d_target, D_MAX).
REQ-030 With BOOST_DMAX_CLAMP_EN undefined, tgt SHALL equal d_target, D_MAX SHALL be unused, and no comparator logic SHALL be generated.

Reset
REQ-031 While rst_n=0, the block SHALL force d_boost=0, state=IDLE, done=0 and divider=0 immediately, asynchronously.
REQ-032 Reset release SHALL take effect on the first clk edge after rst_n rises; assertion mid-ramp or mid-run SHALL discard all progress.

Structure
REQ-033 Package boost_ctrl_pkg SHALL hold DUTY_W=10, the 2-bit state encodings and the STEP and RAMP_DIV defaults.
REQ-034 The tick divider SHALL be a sub-module, boost_tick_div (inputs tick and clr, output step), instantiated once.
REQ-035 The FSM and the duty register SHALL reside in the top module.

Verification
REQ-036 Ramp: STEP=4, RAMP_DIV=1, d_target=100, en=1 -> d_boost steps 4, 8 ... 100 over 25 ticks; done rises on the 25th tick edge.
REQ-037 Non-multiple target: d_target=102 -> 100 after 25 ticks, 102 on the 26th tick; never 104.
REQ-038 Fault: fault pulsed at d_boost=40 -> d_boost=0 and state=3 next edge; fault=0 with en=1 keeps state=3; en=0 -> state=0.
REQ-039 Clamp: d_target=1023 -> d_boost settles at 900 with the macro, at 1023 without it; no 10-bit wrap to a low value.
REQ-040 Stall and retarget: ce=0 for 50 ticks in RAMP -> d_boost frozen; RUN at 200, d_target=60 -> d_boost=60 on next tick; d_target=80 -> RAMP and 64, 68 ... 80.
REQ-041 Reset: rst_n low mid-RUN -> d_boost=0 and state=0 without a clk edge; release with en=1 -> ramp restarts from 0.
